// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared widths, beat counts and FSM states for the ALU sequencer
package alu_seq_pkg;

   localparam int SEL_W      = 3;
   localparam int NIBBLE_W   = 4;
   localparam int DATA_W     = 8;
   localparam int BEATS_FULL = 5;
   localparam int BEATS_ACC  = 3;

   typedef enum logic [2:0] {
      ST_OP   = 3'd0,
      ST_A_LO = 3'd1,
      ST_A_HI = 3'd2,
      ST_B_LO = 3'd3,
      ST_B_HI = 3'd4,
      ST_EXEC = 3'd5,
      ST_RESP = 3'd6
   } state_t;

endpackage

// File: rtl/alu_sequencer_if.sv
// rtl/alu_sequencer_if.sv - command nibble stream and result handshake bundle
interface alu_sequencer_if
   import alu_seq_pkg::*;
();

   logic                cmd_valid;
   logic                cmd_ready;
   logic [NIBBLE_W-1:0] cmd_data;
   logic                res_valid;
   logic                res_ready;
   logic [DATA_W-1:0]   res_data;
   logic                res_cout;
   logic                busy;

   modport master (
      output cmd_valid, cmd_data, res_ready,
      input  cmd_ready, res_valid, res_data, res_cout, busy
   );

   modport slave (
      input  cmd_valid, cmd_data, res_ready,
      output cmd_ready, res_valid, res_data, res_cout, busy
   );

endinterface

// File: rtl/alu_8bit.sv
// rtl/alu_8bit.sv - combinational 8-bit ALU: add, sub, and, or, xor, shl, shr, inc
module alu_8bit
   import alu_seq_pkg::*;
(
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [SEL_W-1:0]  sel,
   output logic [DATA_W-1:0] y,
   output logic              cout
);

   logic [DATA_W:0] wide;

   // cout is carry for add/inc, borrow for sub, shifted-out bit for shifts
   always_comb begin
      wide = '0;
      case (sel)
         3'd0:    wide = {1'b0, a} + {1'b0, b};
         3'd1:    wide = {1'b0, a} - {1'b0, b};
         3'd2:    wide = {1'b0, a & b};
         3'd3:    wide = {1'b0, a | b};
         3'd4:    wide = {1'b0, a ^ b};
         3'd5:    wide = {a, 1'b0};
         3'd6:    wide = {a[0], 1'b0, a[DATA_W-1:1]};
         default: wide = {1'b0, a} + {{DATA_W{1'b0}}, 1'b1};
      endcase
      y    = wide[DATA_W-1:0];
      cout = wide[DATA_W];
   end

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - nibble-serial operand loader driving one alu_8bit; ALU_SEQ_ACC_EN adds accumulator mode
module alu_sequencer
   import alu_seq_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ena,
   alu_sequencer_if.slave  bus
);

   state_t              state_q, state_d;
   logic [SEL_W-1:0]    sel_q;
   logic [DATA_W-1:0]   a_q, b_q, res_q;
   logic                cout_q;
   logic [DATA_W-1:0]   alu_y;
   logic                alu_cout;
   logic                beat, take, acc_skip;

`ifdef ALU_SEQ_ACC_EN
   logic [DATA_W-1:0]   acc_q;
   assign acc_skip = bus.cmd_data[NIBBLE_W-1];
`else
   logic                reserved_bit_unused;
   assign reserved_bit_unused = bus.cmd_data[NIBBLE_W-1];
   assign acc_skip = 1'b0;
`endif

   assign bus.cmd_ready = (state_q != ST_EXEC) && (state_q != ST_RESP);
   assign bus.res_valid = (state_q == ST_RESP);
   assign bus.busy      = (state_q != ST_OP);
   assign bus.res_data  = res_q;
   assign bus.res_cout  = cout_q;

   assign beat = ena && bus.cmd_valid && bus.cmd_ready;
   assign take = ena && bus.res_valid && bus.res_ready;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_OP:   if (beat) state_d = acc_skip ? ST_B_LO : ST_A_LO;
         ST_A_LO: if (beat) state_d = ST_A_HI;
         ST_A_HI: if (beat) state_d = ST_B_LO;
         ST_B_LO: if (beat) state_d = ST_B_HI;
         ST_B_HI: if (beat) state_d = ST_EXEC;
         ST_EXEC: if (ena)  state_d = ST_RESP;
         ST_RESP: if (take) state_d = ST_OP;
         default:           state_d = ST_OP;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_OP;
         sel_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         cout_q  <= 1'b0;
`ifdef ALU_SEQ_ACC_EN
         acc_q   <= '0;
`endif
      end else if (ena) begin
         state_q <= state_d;
         case (state_q)
            ST_OP: if (beat) begin
               sel_q <= bus.cmd_data[SEL_W-1:0];
`ifdef ALU_SEQ_ACC_EN
               // accumulator mode reuses the last result as operand A
               if (acc_skip) a_q <= acc_q;
`endif
            end
            ST_A_LO: if (beat) a_q[NIBBLE_W-1:0]      <= bus.cmd_data;
            ST_A_HI: if (beat) a_q[DATA_W-1:NIBBLE_W] <= bus.cmd_data;
            ST_B_LO: if (beat) b_q[NIBBLE_W-1:0]      <= bus.cmd_data;
            ST_B_HI: if (beat) b_q[DATA_W-1:NIBBLE_W] <= bus.cmd_data;
            ST_EXEC: begin
               res_q  <= alu_y;
               cout_q <= alu_cout;
`ifdef ALU_SEQ_ACC_EN
               acc_q  <= alu_y;
`endif
            end
            default: ;
         endcase
      end
   end

   alu_8bit u_alu (
      .a    (a_q),
      .b    (b_q),
      .sel  (sel_q),
      .y    (alu_y),
      .cout (alu_cout)
   );

endmodule
